// File: rtl/game_status_tracker_pkg.sv
// Shared game-status definitions: state encoding, display codes and limits.
// Also used by the downstream seven-segment/LED display driver.
package game_status_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_PLAY = 2'd1,
      ST_OVER = 2'd2
   } game_state_t;

   localparam logic [4:0] SEG_DASH = 5'd10;
   localparam logic [4:0] HP_MAX   = 5'd9;
   localparam logic [4:0] LED_MAX  = 5'd16;

   // An expired cooldown is shown as a dash rather than a zero.
   function automatic logic [4:0] cd_to_seg(input logic [4:0] cd);
      return (cd == 5'd0) ? SEG_DASH : cd;
   endfunction

endpackage

// File: rtl/game_status_tracker_cooldown_timer.sv
// Skill cooldown: a seconds prescaler plus a down-counter that reloads on a
// granted skill and pauses whenever run is low.
module cooldown_timer
   import game_status_pkg::*;
#(
   parameter int TICK_DIV   = 100_000_000,
   parameter int CD_SECONDS = 9
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       clear,
   input  logic       load,
   input  logic       run,
   output logic [4:0] count,
   output logic       ready
);

   localparam int            PW         = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
   localparam logic [PW-1:0] PRESC_ZERO = {PW{1'b0}};
   localparam logic [PW-1:0] PRESC_ONE  = PW'(1);
   localparam logic [4:0]    CD_LOAD    = 5'(CD_SECONDS);

   logic [PW-1:0] presc_r;
   logic [4:0]    count_r;

   // Prescaler wraps at TICK_DIV-1; each wrap takes one second off a running cooldown.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         presc_r <= PRESC_ZERO;
         count_r <= 5'd0;
      end else if (clear) begin
         presc_r <= PRESC_ZERO;
         count_r <= 5'd0;
      end else if (load) begin
         presc_r <= PRESC_ZERO;
         count_r <= CD_LOAD;
      end else if (run) begin
         if (presc_r == PRESC_LAST) begin
            presc_r <= PRESC_ZERO;
            if (count_r != 5'd0) begin
               count_r <= count_r - 5'd1;
            end
         end else begin
            presc_r <= presc_r + PRESC_ONE;
         end
      end
   end

   assign count = count_r;
   assign ready = (count_r == 5'd0);

endmodule

// File: rtl/game_status_tracker.sv
// Game-state bookkeeping ahead of the display driver: IDLE/PLAY/OVER FSM,
// saturating HP and pick counters, skill grant and cooldown display codes.
module game_status_tracker
   import game_status_pkg::*;
#(
   parameter int TICK_DIV   = 100_000_000,
   parameter int CD_SECONDS = 9,
   parameter int HP_INIT    = 9,
   parameter int PICK_MAX   = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       damage,
   input  logic       heal,
   input  logic       pick,
   input  logic       skill,
   output logic       skill_fire,
   output logic       won,
   output logic       lost,
   output logic [1:0] game_state,
   output logic [4:0] seg7_hp,
   output logic [4:0] seg7_cd,
   output logic [4:0] led_picked
);

   localparam logic [4:0] HP_LOAD  = 5'(HP_INIT);
   localparam logic [4:0] PICK_LIM = 5'(PICK_MAX);

   game_state_t state_r;
   logic [4:0]  hp_r;
   logic [4:0]  picked_r;
   logic        won_r;
   logic        lost_r;
   logic        fire_r;

   logic [4:0]  hp_next_s;
   logic [4:0]  picked_next_s;
   logic        fire_s;
   logic        playing_s;
   logic [4:0]  cd_count_s;
   logic        cd_ready_s;

   assign playing_s = (state_r == ST_PLAY);

   cooldown_timer #(
      .TICK_DIV   (TICK_DIV),
      .CD_SECONDS (CD_SECONDS)
   ) u_cooldown (
      .clk   (clk),
      .rst   (rst),
      .clear (start),
      .load  (fire_s),
      .run   (playing_s),
      .count (cd_count_s),
      .ready (cd_ready_s)
   );

   // Next counter values and skill grant while in play; frozen otherwise.
   always_comb begin
      hp_next_s     = hp_r;
      picked_next_s = picked_r;
      fire_s        = 1'b0;
      if (playing_s) begin
         case ({damage, heal})
            2'b10: begin
               if (hp_r != 5'd0) begin
                  hp_next_s = hp_r - 5'd1;
               end else begin
                  hp_next_s = hp_r;
               end
            end
            2'b01: begin
               if (hp_r != HP_MAX) begin
                  hp_next_s = hp_r + 5'd1;
               end else begin
                  hp_next_s = hp_r;
               end
            end
            default: hp_next_s = hp_r;
         endcase
         if (pick && (picked_r != PICK_LIM)) begin
            picked_next_s = picked_r + 5'd1;
         end else begin
            picked_next_s = picked_r;
         end
         fire_s = skill & cd_ready_s & ~start;
      end else begin
         fire_s = 1'b0;
      end
   end

   // Game FSM with registered counters and flags; a loss outranks a win.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r  <= ST_IDLE;
         hp_r     <= HP_LOAD;
         picked_r <= 5'd0;
         won_r    <= 1'b0;
         lost_r   <= 1'b0;
         fire_r   <= 1'b0;
      end else if (start) begin
         state_r  <= ST_PLAY;
         hp_r     <= HP_LOAD;
         picked_r <= 5'd0;
         won_r    <= 1'b0;
         lost_r   <= 1'b0;
         fire_r   <= 1'b0;
      end else begin
         fire_r <= fire_s;
         case (state_r)
            ST_PLAY: begin
               hp_r     <= hp_next_s;
               picked_r <= picked_next_s;
               if (hp_next_s == 5'd0) begin
                  state_r <= ST_OVER;
                  lost_r  <= 1'b1;
               end else if (picked_next_s == PICK_LIM) begin
                  state_r <= ST_OVER;
                  won_r   <= 1'b1;
               end
            end
            ST_IDLE, ST_OVER: begin
               state_r <= state_r;
            end
            default: begin
               state_r <= ST_IDLE;
            end
         endcase
      end
   end

   assign game_state = state_r;
   assign seg7_hp    = hp_r;
   assign seg7_cd    = cd_to_seg(cd_count_s);
   assign led_picked = picked_r;
   assign won        = won_r;
   assign lost       = lost_r;
   assign skill_fire = fire_r;

endmodule

// File: tb/tb_game_status_tracker.sv
// Directed plus randomized bench for game_status_tracker against a
// cycle-count reference model of the game rules.
module tb_game_status_tracker;

   localparam int TD  = 4;
   localparam int CD  = 3;
   localparam int HPI = 3;
   localparam int PM  = 4;

   logic       clk = 1'b0;
   logic       rst;
   logic       start, damage, heal, pick, skill;
   logic       skill_fire, won, lost;
   logic [1:0] game_state;
   logic [4:0] seg7_hp, seg7_cd, led_picked;

   int n_vec = 0;
   int n_err = 0;

   // Reference model: cooldown kept as remaining clock cycles.
   int m_state, m_hp, m_pick, m_cd, m_won, m_lost, m_fire;

   game_status_tracker #(
      .TICK_DIV   (TD),
      .CD_SECONDS (CD),
      .HP_INIT    (HPI),
      .PICK_MAX   (PM)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .damage     (damage),
      .heal       (heal),
      .pick       (pick),
      .skill      (skill),
      .skill_fire (skill_fire),
      .won        (won),
      .lost       (lost),
      .game_state (game_state),
      .seg7_hp    (seg7_hp),
      .seg7_cd    (seg7_cd),
      .led_picked (led_picked)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_state = 0; m_hp = HPI; m_pick = 0; m_cd = 0;
      m_won = 0; m_lost = 0; m_fire = 0;
   endtask

   task automatic model_edge(input bit st, input bit d, input bit h, input bit p, input bit s);
      if (st) begin
         model_reset();
         m_state = 1;
      end else if (m_state == 1) begin
         m_fire = (s && m_cd == 0) ? 1 : 0;
         if (m_fire == 1) m_cd = CD * TD;
         else if (m_cd > 0) m_cd--;
         if (d && !h && m_hp > 0) m_hp--;
         else if (h && !d && m_hp < 9) m_hp++;
         if (p && m_pick < PM) m_pick++;
         if (m_hp == 0) begin
            m_lost = 1; m_state = 2;
         end else if (m_pick == PM) begin
            m_won = 1; m_state = 2;
         end
      end else begin
         m_fire = 0;
      end
   endtask

   function automatic int exp_cd();
      return (m_cd == 0) ? 10 : (m_cd + TD - 1) / TD;
   endfunction

   task automatic check_all(input string w);
      chk({w, ".state"}, 32'(game_state), m_state);
      chk({w, ".hp"},    32'(seg7_hp),    m_hp);
      chk({w, ".cd"},    32'(seg7_cd),    exp_cd());
      chk({w, ".led"},   32'(led_picked), m_pick);
      chk({w, ".won"},   32'(won),        m_won);
      chk({w, ".lost"},  32'(lost),       m_lost);
      chk({w, ".fire"},  32'(skill_fire), m_fire);
   endtask

   task automatic cycle(input bit st, input bit d, input bit h, input bit p, input bit s,
                        input string w);
      start = st; damage = d; heal = h; pick = p; skill = s;
      @(posedge clk);
      model_edge(st, d, h, p, s);
      #1;
      start = 1'b0; damage = 1'b0; heal = 1'b0; pick = 1'b0; skill = 1'b0;
      check_all(w);
   endtask

   // Asynchronous reset between clock edges, checked before any edge arrives.
   task automatic async_reset(input string w);
      #2;
      rst = 1'b1;
      model_reset();
      #1;
      check_all({w, ".now"});
      @(posedge clk);
      #1;
      check_all({w, ".held"});
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      start = 1'b0; damage = 1'b0; heal = 1'b0; pick = 1'b0; skill = 1'b0;
      model_reset();
      #12;
      check_all("reset");
      rst = 1'b0;

      cycle(1, 0, 0, 0, 0, "start");

      for (int i = 0; i < 8; i++) cycle(0, 0, 1, 0, 0, "heal");
      chk("heal_sat", 32'(seg7_hp), 9);
      for (int i = 0; i < 9; i++) cycle(0, 1, 0, 0, 0, "dmg");
      chk("loss_lost", 32'(lost), 1);
      chk("loss_state", 32'(game_state), 2);
      cycle(0, 1, 0, 0, 0, "over_dmg");
      cycle(0, 0, 1, 0, 0, "over_heal");
      chk("over_hp", 32'(seg7_hp), 0);

      cycle(1, 0, 0, 0, 0, "restart");
      cycle(0, 1, 1, 0, 0, "dmg_heal");
      chk("dmg_heal_hp", 32'(seg7_hp), 3);

      cycle(0, 0, 0, 0, 1, "skill_n");
      chk("skill_n_fire", 32'(skill_fire), 1);
      chk("skill_n_cd", 32'(seg7_cd), 3);
      for (int i = 1; i <= 4; i++) cycle(0, 0, 0, 0, 0, "cd_a");
      chk("cd_n4", 32'(seg7_cd), 2);
      cycle(0, 0, 0, 0, 1, "skill_busy");
      chk("skill_busy_fire", 32'(skill_fire), 0);
      for (int i = 6; i <= 11; i++) cycle(0, 0, 0, 0, 0, "cd_b");
      chk("cd_n11", 32'(seg7_cd), 1);
      cycle(0, 0, 0, 0, 1, "skill_n12");
      chk("skill_n12_fire", 32'(skill_fire), 0);
      chk("skill_n12_cd", 32'(seg7_cd), 10);
      cycle(0, 0, 0, 0, 1, "skill_n13");
      chk("skill_n13_fire", 32'(skill_fire), 1);

      for (int i = 0; i < 4; i++) cycle(0, 0, 0, 1, 0, "pick");
      chk("win_won", 32'(won), 1);
      chk("win_state", 32'(game_state), 2);

      cycle(1, 0, 0, 0, 0, "tie_start");
      cycle(0, 1, 0, 0, 0, "tie_d1");
      cycle(0, 1, 0, 0, 0, "tie_d2");
      for (int i = 0; i < 3; i++) cycle(0, 0, 0, 1, 0, "tie_p");
      cycle(0, 1, 0, 1, 0, "tie");
      chk("tie_lost", 32'(lost), 1);
      chk("tie_won", 32'(won), 0);
      chk("tie_led", 32'(led_picked), 4);

      cycle(1, 0, 0, 0, 0, "rst_start");
      cycle(0, 0, 0, 0, 1, "rst_skill");
      for (int i = 0; i < 4; i++) cycle(0, 0, 0, 0, 0, "rst_cd");
      chk("rst_cd2", 32'(seg7_cd), 2);
      async_reset("mid_rst");
      chk("mid_rst_cd", 32'(seg7_cd), 10);
      chk("mid_rst_state", 32'(game_state), 0);

      cycle(1, 0, 0, 0, 0, "over_start");
      for (int i = 0; i < 3; i++) cycle(0, 1, 0, 0, 0, "over_d");
      cycle(1, 0, 0, 0, 0, "from_over");
      chk("from_over_state", 32'(game_state), 1);
      chk("from_over_hp", 32'(seg7_hp), 3);

      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 149) == 0) begin
            async_reset("rnd_rst");
         end else begin
            cycle($urandom_range(0, 39) == 0, $urandom_range(0, 3) == 0,
                  $urandom_range(0, 2) == 0, $urandom_range(0, 4) == 0,
                  $urandom_range(0, 3) == 0, "rnd");
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/game_status_tracker.md
# game_status_tracker

Game-state bookkeeping stage that sits directly upstream of the seven-segment/LED display driver. It turns single-cycle gameplay event pulses (damage, heal, item pick, skill request, start) into player HP, a skill cooldown countdown and a picked-item count. These are presented as the 5-bit display codes the driver consumes: `seg7_hp`, `seg7_cd` and `led_picked`. It also runs the IDLE/PLAY/OVER game state machine and flags win/loss.

## Interface
- `TICK_DIV`, 100_000_000 — clk cycles per cooldown second; must be ≥ 2.
- `CD_SECONDS`, 9 — cooldown length in seconds; range 1..9.
- `HP_INIT`, 9 — HP loaded on start and on reset; range 1..9.
- `PICK_MAX`, 16 — item count that wins the game; range 1..16.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  reset; asynchronous, active-high.
- `start`  in  1  pulse; begins or restarts a game.
- `damage`  in  1  pulse; HP −1.
- `heal`  in  1  pulse; HP +1.
- `pick`  in  1  pulse; item count +1.
- `skill`  in  1  pulse; skill request.
- `skill_fire`  out  1  one-cycle grant pulse.
- `won`  out  1  level; game ended by reaching `PICK_MAX`.
- `lost`  out  1  level; game ended by HP reaching 0.
- `game_state`  out  2  IDLE=0, PLAY=1, OVER=2.
- `seg7_hp`  out  5  HP, 0..9.
- `seg7_cd`  out  5  remaining cooldown 1..9, or 10 (dash) when the skill is ready.
- `led_picked`  out  5  item count, 0..16.

## Operation
- All inputs are synchronous to `clk` and already debounced/one-pulsed upstream. A pulse is sampled on a single rising edge.
- Reset and IDLE values: `game_state`=IDLE, `seg7_hp`=`HP_INIT`, `seg7_cd`=10, `led_picked`=0, `skill_fire`=0, `won`=0, `lost`=0, prescaler=0.
- **IDLE**: only `start` is honoured. On `start`, the state goes to PLAY and all counters are (re)loaded to their reset values.
- **PLAY**:
  - `damage` decrements HP, saturating at 0.
  - `heal` increments HP, saturating at 9.
  - `damage` and `heal` in the same cycle leave HP unchanged.
  - `pick` increments the count, saturating at `PICK_MAX`.
  - `skill` while `seg7_cd`=10 produces a `skill_fire` pulse, loads cooldown=`CD_SECONDS` and clears the prescaler. `skill` during an active cooldown is ignored (no pulse).
  - A second tick is generated when the prescaler equals `TICK_DIV`−1; the prescaler then wraps to 0. Each tick decrements a non-zero cooldown. A cooldown of 0 is displayed as 10.
  - HP becoming 0 causes OVER with `lost`=1.
  - The count becoming `PICK_MAX` causes OVER with `won`=1.
  - If both happen in the same cycle, loss wins: `lost`=1, `won`=0.
- **OVER**:
  - All counters are frozen; the cooldown stops and the prescaler holds.
  - `damage`, `heal`, `pick` and `skill` are ignored.
  - `start` reloads the counters, clears `won` and `lost`, and enters PLAY.
- `start` during PLAY restarts the game identically (counters reload; state stays PLAY).
- All arithmetic uses 5-bit unsigned values; no output ever leaves its stated range.

## Timing
- Every output is registered. An event sampled at edge N is visible after edge N.
- `skill_fire` is high for exactly the one cycle after the accepted `skill` edge.
- After a skill at edge N, `seg7_cd` shows `CD_SECONDS` from edge N, and decrements at edges N+k·`TICK_DIV` for k=1..`CD_SECONDS`. It reads 10 from edge N+`CD_SECONDS`·`TICK_DIV`. Total cooldown is `CD_SECONDS`·`TICK_DIV` cycles.
- A `skill` on the same edge where the cooldown reaches 0 is rejected; the skill is first available one cycle later.
- `won`/`lost` and `game_state`=OVER assert on the same edge as the terminal counter update.
- Reset asserted mid-game returns every output to its reset value immediately (asynchronously), independent of `clk`.

## Structure
- Shared package `game_status_pkg` holds:
  - the state enumeration (IDLE/PLAY/OVER),
  - `SEG_DASH`=5'd10,
  - `HP_MAX`=9,
  - `LED_MAX`=16.
- The display driver reuses `SEG_DASH` and `LED_MAX` from this package.
- One natural sub-module, `cooldown_timer`, contains the prescaler and down-counter.
  - Inputs: `load`, `run`.
  - Outputs: `count`, `ready`.
- The top level holds the FSM and the HP and pick counters.

## Test plan
Simulate with `TICK_DIV`=4, `CD_SECONDS`=3, `HP_INIT`=3, `PICK_MAX`=4.
- **Reset/start**: after reset, outputs are hp=3, cd=10, led=0, state=0. Pulse `start` → state=1, all other outputs unchanged.
- **HP saturation and loss**: `heal`×8 → hp=9 (saturates). Then `damage`×9 → hp=0, `lost`=1, state=2; further `damage`/`heal` leave hp=0.
- **Simultaneous damage+heal**: at hp=3, `damage` and `heal` in the same cycle → hp stays 3.
- **Skill cooldown**: `skill` at edge N → `skill_fire` high for one cycle; cd=3 at N, 2 at N+4, 1 at N+8, 10 at N+12. `skill` at N+5 → no pulse, cd unaffected. `skill` at N+12 rejected; `skill` at N+13 accepted.
- **Win and tie priority**: `pick`×4 → led=4, `won`=1, state=2. Restart with hp=1 and led=3, then apply `damage`+`pick` in the same cycle → `lost`=1, `won`=0, led=4.
- **Reset mid-cooldown / restart from OVER**: assert `rst` at cd=2 → cd=10, state=0 immediately. Reach OVER, pulse `start` → state=1, hp=3, cd=10, led=0, won=lost=0.
